// File: rtl/cpu_mem_pkg.sv
// Shared types and widths for the memory-response path between L2 and the cache requestors.
package cpu_mem_pkg;

  localparam int unsigned PHYSICAL_ADDR_WIDTH = 32;
  localparam int unsigned BYTE_WIDTH          = 8;
  localparam int unsigned LINE_WIDTH          = 64;
  localparam int unsigned MEM_ADDR_WIDTH      =
      PHYSICAL_ADDR_WIDTH - $clog2(LINE_WIDTH / BYTE_WIDTH);
  localparam int unsigned NUM_PORTS_DEFAULT   = 2;
  localparam int unsigned PORT_W_DEFAULT      = $clog2(NUM_PORTS_DEFAULT);

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0]     data;
    logic [PORT_W_DEFAULT-1:0] port;
  } mem_resp_t;

endpackage

// File: rtl/cpu_sync_fifo.sv
// Generic circular FIFO with occupancy count; flush empties it in one cycle.
module cpu_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[head_q];
  assign count   = count_q;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      // Same-cycle traffic is discarded along with the queued entries.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[tail_q] = wdata;
        tail_d        = tail_q + PtrW'(1);
      end
      if (pop_ok) begin
        head_d = head_q + PtrW'(1);
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + CntW'(1);
      end else if (!push_ok && pop_ok) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cpu_mem_resp_buffer.sv
// In-order memory-response buffer: queues tagged line fills and hands each to its port
// with valid/ready back-pressure, plus flush and a sticky overflow flag.
module cpu_mem_resp_buffer
  import cpu_mem_pkg::*;
#(
  parameter int unsigned LINE_WIDTH     = cpu_mem_pkg::LINE_WIDTH,
  parameter int unsigned MEM_ADDR_WIDTH = cpu_mem_pkg::MEM_ADDR_WIDTH,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned PORT_W         = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LINE_WIDTH-1:0]       in_data,
  input  logic [MEM_ADDR_WIDTH-1:0]   in_addr,
  input  logic [PORT_W-1:0]           in_port,
  output logic [NUM_PORTS-1:0]        out_valid,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [LINE_WIDTH-1:0]       out_data,
  output logic [MEM_ADDR_WIDTH-1:0]   out_addr,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        overflow_err
);

  localparam int unsigned EntryW = MEM_ADDR_WIDTH + LINE_WIDTH + PORT_W;

  logic [EntryW-1:0] wr_entry, rd_entry;
  logic [PORT_W-1:0] head_port;
  logic              full, empty, push, pop;
  logic              overflow_q, overflow_d;

  assign wr_entry = {in_addr, in_data, in_port};
  assign {out_addr, out_data, head_port} = rd_entry;

  assign in_ready     = ~full;
  assign push         = in_valid & in_ready;
  assign pop          = |(out_valid & out_ready);
  assign overflow_err = overflow_q;

  always_comb begin
    out_valid = '0;
    // Out-of-range tags are never offered, so such an entry stalls the head.
    if (!empty && (32'(head_port) < NUM_PORTS)) begin
      out_valid[head_port] = 1'b1;
    end
  end

  always_comb begin
    overflow_d = overflow_q | (in_valid & ~in_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  cpu_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_cpu_mem_resp_buffer.sv
// Directed bench for cpu_mem_resp_buffer with DEPTH=4, NUM_PORTS=2.
module tb_cpu_mem_resp_buffer;

  localparam int unsigned LW    = 64;
  localparam int unsigned AW    = 29;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NP    = 2;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready;
  logic [LW-1:0] in_data, out_data;
  logic [AW-1:0] in_addr, out_addr;
  logic          in_port;
  logic [NP-1:0] out_valid, out_ready;
  logic [2:0]    count;
  logic          overflow_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_mem_resp_buffer #(
    .LINE_WIDTH     (LW),
    .MEM_ADDR_WIDTH (AW),
    .DEPTH          (DEPTH),
    .NUM_PORTS      (NP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_addr      (in_addr),
    .in_port      (in_port),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_addr     (out_addr),
    .count        (count),
    .overflow_err (overflow_err)
  );

  a_port_legal: assert property (@(posedge clk) disable iff (reset)
      in_valid |-> (32'(in_port) < NP));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] data_of(input logic [AW-1:0] a);
    return {32'hA5A5_A5A5, 3'b000, a};
  endfunction

  task automatic drive_push(input logic [AW-1:0] a, input logic p);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = data_of(a);
    in_port  = p;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_addr = '0;
    in_port = 1'b0; out_ready = '0;
    do_reset();
    check("rst_count", 64'(count), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_overflow", 64'(overflow_err), 0);

    // Single push for port 1, visible one cycle later.
    drive_push(29'h12, 1'b1);
    step();
    in_valid = 1'b0;
    check("single_valid", 64'(out_valid), 64'h2);
    check("single_addr", 64'(out_addr), 64'h12);
    check("single_data", out_data, data_of(29'h12));
    check("single_count", 64'(count), 1);
    out_ready = 2'b10;
    step();
    out_ready = 2'b00;
    check("single_pop_count", 64'(count), 0);
    check("single_pop_valid", 64'(out_valid), 0);

    // Fill to full, then one overflowing push that must be dropped.
    for (int i = 0; i < 4; i++) begin
      drive_push(AW'(32'h20 + i), i[0]);
      step();
    end
    in_valid = 1'b0;
    check("full_count", 64'(count), 4);
    check("full_in_ready", 64'(in_ready), 0);
    check("full_no_ovf_yet", 64'(overflow_err), 0);
    drive_push(29'h99, 1'b0);
    step();
    in_valid = 1'b0;
    check("ovf_set", 64'(overflow_err), 1);
    check("ovf_count", 64'(count), 4);
    for (int i = 0; i < 4; i++) begin
      check("drain_addr", 64'(out_addr), 64'h20 + 64'(i));
      check("drain_valid", 64'(out_valid), (i % 2 == 0) ? 64'h1 : 64'h2);
      out_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
    end
    out_ready = '0;
    check("drain_empty", 64'(count), 0);
    check("ovf_sticky", 64'(overflow_err), 1);

    // Head for port 0 must ignore port 1's ready.
    drive_push(29'h30, 1'b0);
    step();
    in_valid  = 1'b0;
    out_ready = 2'b10;
    for (int i = 0; i < 5; i++) step();
    check("stall_count", 64'(count), 1);
    check("stall_addr", 64'(out_addr), 64'h30);
    out_ready = 2'b01;
    step();
    out_ready = '0;
    check("stall_release", 64'(count), 0);

    // Sustained push+pop with alternating ports; pointers wrap several times.
    drive_push(29'h40, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      check("stream_addr", 64'(out_addr), 64'h40 + 64'(i));
      drive_push(AW'(32'h41 + i), ~i[0]);
      out_ready = i[0] ? 2'b10 : 2'b01;
      step();
      check("stream_count", 64'(count), 1);
    end
    in_valid = 1'b0;
    check("stream_last", 64'(out_addr), 64'h54);
    out_ready = 2'b01;
    step();
    out_ready = '0;
    check("stream_empty", 64'(count), 0);

    // Reset clears the sticky flag.
    do_reset();
    check("ovf_cleared", 64'(overflow_err), 0);

    // Full with simultaneous pop and push: pop wins, push refused and flagged.
    for (int i = 0; i < 4; i++) begin
      drive_push(AW'(32'h60 + i), i[0]);
      step();
    end
    drive_push(29'h70, 1'b1);
    out_ready = 2'b01;
    step();
    in_valid  = 1'b0;
    out_ready = '0;
    check("fullpop_count", 64'(count), 3);
    check("fullpop_ovf", 64'(overflow_err), 1);
    check("fullpop_head", 64'(out_addr), 64'h61);
    check("fullpop_in_ready", 64'(in_ready), 1);

    // Flush with a concurrent push discards everything.
    drive_push(29'h80, 1'b0);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", 64'(count), 0);
    check("flush_valid", 64'(out_valid), 0);
    check("flush_ovf", 64'(overflow_err), 1);
    check("flush_in_ready", 64'(in_ready), 1);
    drive_push(29'h81, 1'b1);
    step();
    in_valid = 1'b0;
    check("post_flush_addr", 64'(out_addr), 64'h81);
    check("post_flush_valid", 64'(out_valid), 64'h2);
    out_ready = 2'b10;
    step();
    out_ready = '0;
    check("post_flush_pop", 64'(count), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
